// File: rtl/lvds_align_ctrl.sv
// Word-alignment training sequencer for the sensor LVDS deserializer lanes.
// Trains one lane at a time by bitslipping until TRAIN_WORD is seen CHECK_CNT times in a row.
module lvds_align_ctrl #(
    parameter int unsigned      LANES      = 4,
    parameter int unsigned      WIDTH      = 12,
    parameter logic [WIDTH-1:0] TRAIN_WORD = 12'h0F0,
    parameter int unsigned      SETTLE_CYC = 8,
    parameter int unsigned      CHECK_CNT  = 16,
    parameter int unsigned      MAX_SLIP   = 12,
    localparam int unsigned     LW         = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_lane_vld,
    input  logic [LANES*WIDTH-1:0] i_lane_data,
    output logic [LANES-1:0]       o_bitslip,
    output logic [LANES-1:0]       o_lane_locked,
    output logic [LW-1:0]          o_cur_lane,
    output logic                   o_busy,
    output logic                   o_align_done,
    output logic                   o_align_fail
);

    localparam int unsigned SW = (SETTLE_CYC + 1 > 1) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam int unsigned MW = (CHECK_CNT + 1 > 1) ? $clog2(CHECK_CNT + 1) : 1;
    localparam int unsigned PW = (MAX_SLIP + 1 > 1) ? $clog2(MAX_SLIP + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCheck,
        StSlip,
        StNext,
        StDone,
        StFail
    } state_e;

    state_e           r_state,      w_state_next;
    logic [SW-1:0]    r_settle_cnt, w_settle_next;
    logic [MW-1:0]    r_match_cnt,  w_match_next;
    logic [PW-1:0]    r_slip_cnt,   w_slip_next;
    logic [LW-1:0]    r_cur_lane,   w_lane_next;
    logic [LANES-1:0] r_lane_locked, w_locked_next;
    logic [LANES-1:0] r_bitslip,    w_bitslip_next;
    logic [WIDTH-1:0] w_word;

    assign w_word = i_lane_data[r_cur_lane*WIDTH +: WIDTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_settle_cnt  <= '0;
            r_match_cnt   <= '0;
            r_slip_cnt    <= '0;
            r_cur_lane    <= '0;
            r_lane_locked <= '0;
            r_bitslip     <= '0;
        end else begin
            r_state       <= w_state_next;
            r_settle_cnt  <= w_settle_next;
            r_match_cnt   <= w_match_next;
            r_slip_cnt    <= w_slip_next;
            r_cur_lane    <= w_lane_next;
            r_lane_locked <= w_locked_next;
            r_bitslip     <= w_bitslip_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_settle_next  = r_settle_cnt;
        w_match_next   = r_match_cnt;
        w_slip_next    = r_slip_cnt;
        w_lane_next    = r_cur_lane;
        w_locked_next  = r_lane_locked;
        w_bitslip_next = '0;
        unique case (r_state)
            StIdle, StDone, StFail: begin
                if (i_start) begin
                    w_state_next  = StSettle;
                    w_lane_next   = '0;
                    w_slip_next   = '0;
                    w_match_next  = '0;
                    w_settle_next = '0;
                    w_locked_next = '0;
                end
            end
            StSettle: begin
                if (r_settle_cnt == SW'(SETTLE_CYC - 1)) begin
                    w_state_next  = StCheck;
                    w_settle_next = '0;
                end else begin
                    w_settle_next = r_settle_cnt + SW'(1);
                end
            end
            StCheck: begin
                if (i_lane_vld) begin
                    if (w_word == TRAIN_WORD) begin
                        if (r_match_cnt == MW'(CHECK_CNT - 1)) begin
                            w_state_next              = StNext;
                            w_match_next              = '0;
                            w_locked_next[r_cur_lane] = 1'b1;
                        end else begin
                            w_match_next = r_match_cnt + MW'(1);
                        end
                    end else if (r_slip_cnt < PW'(MAX_SLIP)) begin
                        // Pulse is registered on entry so it lines up with the SLIP cycle.
                        w_state_next               = StSlip;
                        w_match_next               = '0;
                        w_bitslip_next[r_cur_lane] = 1'b1;
                    end else begin
                        w_state_next = StFail;
                    end
                end
            end
            StSlip: begin
                w_slip_next  = r_slip_cnt + PW'(1);
                w_state_next = StSettle;
            end
            StNext: begin
                if (r_cur_lane == LW'(LANES - 1)) begin
                    w_state_next = StDone;
                end else begin
                    w_lane_next  = r_cur_lane + LW'(1);
                    w_slip_next  = '0;
                    w_match_next = '0;
                    w_state_next = StSettle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign o_bitslip     = r_bitslip;
    assign o_lane_locked = r_lane_locked;
    assign o_cur_lane    = r_cur_lane;
    assign o_busy        = (r_state == StSettle) || (r_state == StCheck) ||
                           (r_state == StSlip)   || (r_state == StNext);
    assign o_align_done  = (r_state == StDone);
    assign o_align_fail  = (r_state == StFail);

endmodule

// File: tb/tb_lvds_align_ctrl.sv
// Directed bench for lvds_align_ctrl with a rotating-serdes lane model.
// Cycle n means the value seen just after the n-th rising edge, start being sampled on edge 1.
module tb_lvds_align_ctrl;

    localparam int LANES = 4;
    localparam int WIDTH = 12;
    localparam logic [WIDTH-1:0] TRAIN = 12'h0F0;

    logic                   clk = 1'b0;
    logic                   i_rst;
    logic                   i_start;
    logic                   i_lane_vld;
    logic [LANES*WIDTH-1:0] i_lane_data;
    logic [LANES-1:0]       o_bitslip;
    logic [LANES-1:0]       o_lane_locked;
    logic [1:0]             o_cur_lane;
    logic                   o_busy;
    logic                   o_align_done;
    logic                   o_align_fail;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rot[LANES];
    int slips[LANES];
    bit bad[LANES];
    bit apply_slip;
    bit toggle_vld;
    int corrupt_edge;

    lvds_align_ctrl dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_lane_vld   (i_lane_vld),
        .i_lane_data  (i_lane_data),
        .o_bitslip    (o_bitslip),
        .o_lane_locked(o_lane_locked),
        .o_cur_lane   (o_cur_lane),
        .o_busy       (o_busy),
        .o_align_done (o_align_done),
        .o_align_fail (o_align_fail)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] w, input int r);
        return (w << r) | (w >> (WIDTH - r));
    endfunction

    // Drives the lane words and vld to be sampled on the next edge (cyc+1).
    task automatic update_data();
        for (int l = 0; l < LANES; l++) begin
            logic [WIDTH-1:0] w;
            w = bad[l] ? '0 : rotl(TRAIN, rot[l]);
            if (l == 0 && cyc + 1 == corrupt_edge) w = w ^ 12'h001;
            i_lane_data[l*WIDTH +: WIDTH] = w;
        end
        i_lane_vld = toggle_vld ? ((cyc + 1) % 2 == 1) : 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int l = 0; l < LANES; l++) begin
            if (o_bitslip[l]) begin
                slips[l]++;
                if (apply_slip) rot[l] = (rot[l] == 0) ? WIDTH - 1 : rot[l] - 1;
            end
        end
        checks++;
        if (o_align_done && o_align_fail) begin
            errors++;
            $display("FAIL done_fail_excl cyc=%0d both flags set", cyc);
        end
        update_data();
    endtask

    task automatic init_model();
        for (int l = 0; l < LANES; l++) begin
            rot[l]   = 0;
            slips[l] = 0;
            bad[l]   = 1'b0;
        end
        apply_slip   = 1'b1;
        toggle_vld   = 1'b0;
        corrupt_edge = -1;
        cyc          = 0;
        update_data();
    endtask

    task automatic apply_reset();
        i_rst   = 1'b1;
        i_start = 1'b0;
        init_model();
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        cyc   = 0;
    endtask

    task automatic do_start();
        cyc = 0;
        update_data();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic test_reset();
        i_rst   = 1'b1;
        i_start = 1'b0;
        init_model();
        #1;
        checks++;
        if ({o_bitslip, o_lane_locked, o_cur_lane, o_busy, o_align_done, o_align_fail} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b required 0",
                     {o_bitslip, o_lane_locked, o_cur_lane, o_busy, o_align_done, o_align_fail});
        end
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (o_busy !== 1'b0 || o_align_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold busy=%b done=%b required 0 0", o_busy, o_align_done);
        end
    endtask

    task automatic test_all_aligned();
        logic [3:0] exp_locked;
        int         exp_lane;
        apply_reset();
        do_start();
        forever begin
            exp_locked = (cyc >= 100) ? 4'b1111 : (cyc >= 75) ? 4'b0111 :
                         (cyc >= 50)  ? 4'b0011 : (cyc >= 25) ? 4'b0001 : 4'b0000;
            exp_lane   = (cyc <= 25) ? 0 : (cyc <= 50) ? 1 : (cyc <= 75) ? 2 : 3;
            checks++;
            if (o_lane_locked !== exp_locked) begin
                errors++;
                $display("FAIL t1_locked cyc=%0d got %b required %b", cyc, o_lane_locked, exp_locked);
            end
            checks++;
            if (o_align_done !== (cyc >= 101) || o_busy !== (cyc <= 100)) begin
                errors++;
                $display("FAIL t1_done_busy cyc=%0d done=%b busy=%b", cyc, o_align_done, o_busy);
            end
            checks++;
            if (int'(o_cur_lane) != exp_lane) begin
                errors++;
                $display("FAIL t1_cur_lane cyc=%0d got %0d required %0d", cyc, o_cur_lane, exp_lane);
            end
            if (cyc >= 101) break;
            tick();
        end
        checks++;
        if (slips[0] + slips[1] + slips[2] + slips[3] != 0) begin
            errors++;
            $display("FAIL t1_no_bitslip got %0d pulses required 0",
                     slips[0] + slips[1] + slips[2] + slips[3]);
        end
    endtask

    task automatic test_slip_recovery();
        apply_reset();
        rot[2] = 3;
        do_start();
        while (!o_align_done && cyc < 400) tick();
        checks++;
        if (cyc != 131) begin
            errors++;
            $display("FAIL t2_done_cycle got %0d required 131", cyc);
        end
        checks++;
        if (slips[2] != 3 || slips[0] + slips[1] + slips[3] != 0) begin
            errors++;
            $display("FAIL t2_slips lane2=%0d others=%0d required 3 and 0",
                     slips[2], slips[0] + slips[1] + slips[3]);
        end
        checks++;
        if (o_lane_locked !== 4'hF) begin
            errors++;
            $display("FAIL t2_locked got %b required 1111", o_lane_locked);
        end
    endtask

    task automatic test_lane_fail();
        apply_reset();
        bad[1] = 1'b1;
        do_start();
        while (!o_align_fail && cyc < 400) tick();
        checks++;
        if (cyc != 155) begin
            errors++;
            $display("FAIL t3_fail_cycle got %0d required 155", cyc);
        end
        checks++;
        if (slips[1] != 12 || slips[0] != 0) begin
            errors++;
            $display("FAIL t3_slips lane1=%0d lane0=%0d required 12 and 0", slips[1], slips[0]);
        end
        checks++;
        if (o_cur_lane !== 2'd1 || o_lane_locked !== 4'b0001 || o_busy !== 1'b0 ||
            o_align_done !== 1'b0 || o_align_fail !== 1'b1) begin
            errors++;
            $display("FAIL t3_final lane=%0d locked=%b busy=%b done=%b fail=%b",
                     o_cur_lane, o_lane_locked, o_busy, o_align_done, o_align_fail);
        end
        tick();
        checks++;
        if (o_bitslip !== '0) begin
            errors++;
            $display("FAIL t3_no_pulse_at_fail got %b required 0", o_bitslip);
        end
    endtask

    task automatic test_vld_toggle();
        apply_reset();
        toggle_vld = 1'b1;
        do_start();
        run_to(40);
        checks++;
        if (o_lane_locked !== 4'b0000) begin
            errors++;
            $display("FAIL t4_early got %b required 0000", o_lane_locked);
        end
        tick();
        checks++;
        if (o_lane_locked !== 4'b0001) begin
            errors++;
            $display("FAIL t4_lock41 got %b required 0001", o_lane_locked);
        end
    endtask

    task automatic test_corrupt_and_busy_start();
        apply_reset();
        apply_slip   = 1'b0;
        corrupt_edge = 25;
        do_start();
        run_to(25);
        checks++;
        if (o_lane_locked !== 4'b0000 || o_bitslip !== 4'b0001) begin
            errors++;
            $display("FAIL t5_slip25 locked=%b bitslip=%b required 0000 0001",
                     o_lane_locked, o_bitslip);
        end
        run_to(49);
        checks++;
        if (o_lane_locked !== 4'b0000) begin
            errors++;
            $display("FAIL t5_relock_early got %b required 0000", o_lane_locked);
        end
        tick();
        checks++;
        if (o_lane_locked !== 4'b0001 || slips[0] != 1) begin
            errors++;
            $display("FAIL t5_relock50 locked=%b slips=%0d required 0001 1", o_lane_locked, slips[0]);
        end
        run_to(59);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        checks++;
        if (o_cur_lane !== 2'd1 || o_lane_locked !== 4'b0001 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL t5_busy_start lane=%0d locked=%b busy=%b required 1 0001 1",
                     o_cur_lane, o_lane_locked, o_busy);
        end
        run_to(125);
        checks++;
        if (o_align_done !== 1'b0) begin
            errors++;
            $display("FAIL t5_done_early got %b required 0", o_align_done);
        end
        tick();
        checks++;
        if (o_align_done !== 1'b1 || o_lane_locked !== 4'hF) begin
            errors++;
            $display("FAIL t5_done126 done=%b locked=%b required 1 1111", o_align_done, o_lane_locked);
        end
    endtask

    task automatic test_reset_in_slip();
        apply_reset();
        bad[0] = 1'b1;
        do_start();
        run_to(10);
        checks++;
        if (o_bitslip !== 4'b0001) begin
            errors++;
            $display("FAIL t6_in_slip got %b required 0001", o_bitslip);
        end
        i_rst = 1'b1;
        #1;
        checks++;
        if ({o_bitslip, o_lane_locked, o_cur_lane, o_busy, o_align_done, o_align_fail} !== '0) begin
            errors++;
            $display("FAIL t6_reset_outputs got %b required 0",
                     {o_bitslip, o_lane_locked, o_cur_lane, o_busy, o_align_done, o_align_fail});
        end
        #1;
        i_rst      = 1'b0;
        bad[0]     = 1'b0;
        rot[0]     = 0;
        apply_slip = 1'b0;
        do_start();
        checks++;
        if (o_busy !== 1'b1 || o_cur_lane !== 2'd0) begin
            errors++;
            $display("FAIL t6_restart busy=%b lane=%0d required 1 0", o_busy, o_cur_lane);
        end
        run_to(25);
        checks++;
        if (o_lane_locked !== 4'b0001) begin
            errors++;
            $display("FAIL t6_lock25 got %b required 0001", o_lane_locked);
        end
    endtask

    initial begin
        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_lane_vld  = 1'b0;
        i_lane_data = '0;
        test_reset();
        test_all_aligned();
        test_slip_recovery();
        test_lane_fail();
        test_vld_toggle();
        test_corrupt_and_busy_start();
        test_reset_in_slip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
